img_hflip: RTL

Horizontal-mirror stage for the imager stream pipeline, sitting directly upstream of the rotate stage on `img_clk`. It captures each incoming image line into one half of a ping-pong line buffer. It replays the previously captured line in reverse pixel order from the other half, so the rotate stage receives a standard dvi/dtype/data stream with every row mirrored. Frame and line markers are regenerated so the output remains a well-formed stream.

---
 rtl/img_hflip_if.sv | 21 ++
 rtl/img_hflip.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/img_hflip_if.sv
// img_hflip_if: dv/dtype/data pixel stream bundle shared by the mirror stage and its neighbours.
// The master drives the word and the slave samples it. There is no backpressure.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH       4
`define DTYPE_PXL         4'h0
`define DTYPE_FRAME_START 4'h1
`define DTYPE_HSTART      4'h2
`define DTYPE_HEND        4'h3
`define DTYPE_FRAME_END   4'h4
`endif

interface img_hflip_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic                    dv;
  logic [`DTYPE_WIDTH-1:0] dtype;
  logic [DATA_WIDTH-1:0]   data;

  modport master (output dv, dtype, data);
  modport slave  (input  dv, dtype, data);
endinterface

// File: rtl/img_hflip.sv
// img_hflip: horizontal mirror stage.
// Each captured line goes into one bank of a ping-pong line buffer, while the other bank
// replays the previous line in reverse. Frame markers that arrive during a readout are held
// in a one-deep slot until the readout is finished.
// Optional build macro IMG_HFLIP_OVERRUN_CNT_EN adds a saturating dropped-line counter (overrun_cnt).
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH       4
`define DTYPE_PXL         4'h0
`define DTYPE_FRAME_START 4'h1
`define DTYPE_HSTART      4'h2
`define DTYPE_HEND        4'h3
`define DTYPE_FRAME_END   4'h4
`endif

module img_hflip #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_WIDTH  = 2048,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic        img_clk,
  input  logic        resetb,
  input  logic        enable,
  img_hflip_if.slave  s_in,
  img_hflip_if.master s_out,
  output logic        overrun,
  output logic        too_wide
`ifdef IMG_HFLIP_OVERRUN_CNT_EN
  ,
  output logic [15:0] overrun_cnt
`endif
);

  localparam int unsigned TW    = `DTYPE_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_WIDTH + 1);
  localparam int unsigned IDX_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 * MAX_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_HS, ST_PIX, ST_HE} state_t;

  state_t                state_q;
  logic                  bank_q;      // bank being written; the other bank is read
  logic [CNT_W-1:0]      wcnt_q;
  logic [CNT_W-1:0]      rcnt_q;      // pixels still to be read
  logic                  en_q;
  logic                  overrun_q;
  logic                  too_wide_q;
  logic                  pend_v_q;
  logic [TW-1:0]         pend_ty_q;
  logic [DATA_WIDTH-1:0] pend_d_q;
  logic                  dvo_q;
  logic [TW-1:0]         dtypeo_q;
  logic [DATA_WIDTH-1:0] datao_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic is_fs, is_fe, is_hs, is_he, is_pix, frame_mark, busy;
  logic wr_en, rd_en, pix_drop, swap, line_drop, mark_to_pend, fwd;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  // Input word decode and control strobes for capture, readout and marker routing
  always_comb begin
    is_fs        = s_in.dv && (s_in.dtype == TW'(`DTYPE_FRAME_START));
    is_fe        = s_in.dv && (s_in.dtype == TW'(`DTYPE_FRAME_END));
    is_hs        = s_in.dv && (s_in.dtype == TW'(`DTYPE_HSTART));
    is_he        = s_in.dv && (s_in.dtype == TW'(`DTYPE_HEND));
    is_pix       = s_in.dv && !(is_fs || is_fe || is_hs || is_he);
    frame_mark   = is_fs || is_fe;
    busy         = (state_q != ST_IDLE);
    wr_en        = en_q && is_pix && (wcnt_q < CNT_W'(MAX_WIDTH));
    pix_drop     = en_q && is_pix && (wcnt_q == CNT_W'(MAX_WIDTH));
    swap         = en_q && is_he && !busy;
    line_drop    = en_q && is_he && busy;
    mark_to_pend = frame_mark && (busy || pend_v_q);
    fwd          = (frame_mark && !mark_to_pend) || (!en_q && s_in.dv && !frame_mark);
    rd_en        = ((state_q == ST_HS) || (state_q == ST_PIX)) && (rcnt_q != '0);
    rd_addr      = ADDR_WIDTH'(rcnt_q - CNT_W'(1));
    wr_idx       = bank_q ? IDX_W'(MAX_WIDTH) + IDX_W'(ADDR_WIDTH'(wcnt_q))
                          : IDX_W'(ADDR_WIDTH'(wcnt_q));
    rd_idx       = bank_q ? IDX_W'(rd_addr) : IDX_W'(MAX_WIDTH) + IDX_W'(rd_addr);
  end

  // Line buffer: pixel write into bank W, synchronous read from bank R
  always_ff @(posedge img_clk) begin
    if (wr_en) mem[wr_idx] <= s_in.data;
    if (rd_en) rdata_q <= mem[rd_idx];
  end

  // Capture counters, sticky flags, pending marker slot, readout FSM and registered output word
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      bank_q     <= 1'b0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      en_q       <= 1'b0;
      overrun_q  <= 1'b0;
      too_wide_q <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_ty_q  <= '0;
      pend_d_q   <= '0;
      dvo_q      <= 1'b0;
      dtypeo_q   <= '0;
      datao_q    <= '0;
    end else begin
      dvo_q <= 1'b0;
      if (is_fs) en_q <= enable;

      if (en_q && is_hs)  wcnt_q <= '0;
      else if (wr_en)     wcnt_q <= wcnt_q + CNT_W'(1);

      if (is_fs) begin
        overrun_q  <= 1'b0;
        too_wide_q <= 1'b0;
      end else begin
        if (pix_drop)  too_wide_q <= 1'b1;
        if (line_drop) overrun_q  <= 1'b1;
      end

      if (mark_to_pend) begin
        pend_v_q  <= 1'b1;
        pend_ty_q <= s_in.dtype;
        pend_d_q  <= s_in.data;
      end else if (!busy && pend_v_q) begin
        pend_v_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (swap) begin
            state_q <= ST_HS;
            bank_q  <= ~bank_q;
            rcnt_q  <= wcnt_q;
          end
          if (pend_v_q) begin
            dvo_q    <= 1'b1;
            dtypeo_q <= pend_ty_q;
            datao_q  <= pend_d_q;
          end else if (fwd) begin
            dvo_q    <= 1'b1;
            dtypeo_q <= s_in.dtype;
            datao_q  <= s_in.data;
          end
        end
        ST_HS, ST_PIX: begin
          dvo_q    <= 1'b1;
          dtypeo_q <= (state_q == ST_HS) ? TW'(`DTYPE_HSTART) : TW'(`DTYPE_PXL);
          datao_q  <= (state_q == ST_HS) ? '0 : rdata_q;
          if (rcnt_q == '0) begin
            state_q <= ST_HE;
          end else begin
            state_q <= ST_PIX;
            rcnt_q  <= rcnt_q - CNT_W'(1);
          end
        end
        ST_HE: begin
          dvo_q    <= 1'b1;
          dtypeo_q <= TW'(`DTYPE_HEND);
          datao_q  <= '0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef IMG_HFLIP_OVERRUN_CNT_EN
  logic [15:0] ovf_cnt_q;

  // Saturating count of dropped lines, cleared per frame
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb)                             ovf_cnt_q <= '0;
    else if (is_fs)                          ovf_cnt_q <= '0;
    else if (line_drop && ovf_cnt_q != '1)   ovf_cnt_q <= ovf_cnt_q + 16'd1;
  end

  assign overrun_cnt = ovf_cnt_q;
`endif

  assign s_out.dv    = dvo_q;
  assign s_out.dtype = dtypeo_q;
  assign s_out.data  = datao_q;
  assign overrun     = overrun_q;
  assign too_wide    = too_wide_q;

endmodule
